// File: rtl/xalu_ise_pcpi.sv
// xalu_ise_pcpi: issue/response adapter between the RV32 core PCPI port and
// the combinational Alzette/ELL ISE datapath (xalu_ise).
//
// Custom-0..3 instruction words are decoded into ise_fn/ise_imm. Operands are
// registered, ise_val is held for LAT+1 cycles, and the datapath result is
// captured and returned with a one-cycle pcpi_ready/pcpi_wr pulse.
// Words the adapter does not claim get no response, so the core's timeout
// trap handles them.
//
// Parameters:
//   LAT         extra execute cycles before sampling x_out/x_oval (0..7)
// Ports:
//   ise_clk     clock
//   ise_rst     synchronous active-high reset
//   pcpi_valid  core presents an instruction
//   pcpi_insn   instruction word
//   pcpi_rs1    rs1 operand
//   pcpi_rs2    rs2 operand
//   pcpi_wr     write pcpi_rd to rd (pulses with pcpi_ready)
//   pcpi_rd     result
//   pcpi_wait   execution in progress
//   pcpi_ready  one-cycle completion pulse
//   x_fn        ise_fn to datapath
//   x_imm       ise_imm to datapath
//   x_in1       ise_in1 to datapath
//   x_in2       ise_in2 to datapath
//   x_val       ise_val to datapath
//   x_oval      datapath claimed the operation
//   x_out       datapath result
module xalu_ise_pcpi #(
  parameter int unsigned LAT = 0
) (
  input  logic        ise_clk,
  input  logic        ise_rst,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic [5:0]  x_fn,
  output logic [6:0]  x_imm,
  output logic [31:0] x_in1,
  output logic [31:0] x_in2,
  output logic        x_val,
  input  logic        x_oval,
  input  logic [31:0] x_out
);

  localparam logic [2:0] LAT_C = 3'(LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP,
    S_DONE
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt;
  logic        is_cust;
  logic [1:0]  cust;
  logic [5:0]  dec_fn;
  logic [6:0]  dec_imm;

  // Only opcode, funct3 and funct7 participate in decode.
  logic unused_insn;
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  always_comb begin
    is_cust = 1'b1;
    cust    = 2'd0;
    unique case (pcpi_insn[6:0])
      7'h0B:   cust = 2'd0;
      7'h2B:   cust = 2'd1;
      7'h5B:   cust = 2'd2;
      7'h7B:   cust = 2'd3;
      default: is_cust = 1'b0;
    endcase
    dec_fn  = {1'b0, pcpi_insn[14:12], cust};
    dec_imm = pcpi_insn[31:25];
  end

  // Next state and strobes. Strobes depend on the registered state only,
  // so reset drives them all low on the following cycle.
  always_comb begin
    state_nx   = state;
    x_val      = 1'b0;
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pcpi_valid && is_cust) state_nx = S_EXEC;
      end
      S_EXEC: begin
        x_val     = 1'b1;
        pcpi_wait = 1'b1;
        // A core flush (valid dropping) does not cut the sequence short.
        if (cnt == LAT_C) state_nx = x_oval ? S_RESP : S_DONE;
      end
      S_RESP: begin
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        state_nx   = S_DONE;
      end
      S_DONE: begin
        // Park until the core drops valid so one word is never issued twice.
        if (!pcpi_valid) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge ise_clk) begin
    if (ise_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      x_fn    <= '0;
      x_imm   <= '0;
      x_in1   <= '0;
      x_in2   <= '0;
      pcpi_rd <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: begin
          if (pcpi_valid && is_cust) begin
            x_fn  <= dec_fn;
            x_imm <= dec_imm;
            x_in1 <= pcpi_rs1;
            x_in2 <= pcpi_rs2;
            cnt   <= '0;
          end
        end
        S_EXEC: begin
          if (cnt != LAT_C) begin
            cnt <= cnt + 3'd1;
          end else if (x_oval) begin
            pcpi_rd <= x_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xalu_ise_pcpi.sv
// Self-checking bench for xalu_ise_pcpi. Three instances (LAT = 0, 3, 5) share
// one stimulus stream and one datapath stub; an age-based transaction model
// predicts every output each cycle, and directed literal checks pin the model.
module tb_xalu_ise_pcpi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] insn = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        x_oval = 1'b0;
  logic        xo_inc = 1'b0;
  logic [31:0] xo_const = '0;
  logic [31:0] cyc_q = '0;
  logic [31:0] x_out;

  logic [2:0]  wr_o, wait_o, ready_o, xval_o;
  logic [31:0] rd_o  [3];
  logic [31:0] in1_o [3];
  logic [31:0] in2_o [3];
  logic [5:0]  fn_o  [3];
  logic [6:0]  imm_o [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_q <= cyc_q + 32'd1;

  // Datapath stub: either a constant or a value that changes every cycle.
  assign x_out = xo_inc ? (32'hA500_0000 ^ cyc_q) : xo_const;

  xalu_ise_pcpi #(.LAT(0)) u0 (
    .ise_clk(clk), .ise_rst(rst), .pcpi_valid(valid), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr_o[0]), .pcpi_rd(rd_o[0]),
    .pcpi_wait(wait_o[0]), .pcpi_ready(ready_o[0]), .x_fn(fn_o[0]),
    .x_imm(imm_o[0]), .x_in1(in1_o[0]), .x_in2(in2_o[0]), .x_val(xval_o[0]),
    .x_oval(x_oval), .x_out(x_out));

  xalu_ise_pcpi #(.LAT(3)) u1 (
    .ise_clk(clk), .ise_rst(rst), .pcpi_valid(valid), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr_o[1]), .pcpi_rd(rd_o[1]),
    .pcpi_wait(wait_o[1]), .pcpi_ready(ready_o[1]), .x_fn(fn_o[1]),
    .x_imm(imm_o[1]), .x_in1(in1_o[1]), .x_in2(in2_o[1]), .x_val(xval_o[1]),
    .x_oval(x_oval), .x_out(x_out));

  xalu_ise_pcpi #(.LAT(5)) u2 (
    .ise_clk(clk), .ise_rst(rst), .pcpi_valid(valid), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr_o[2]), .pcpi_rd(rd_o[2]),
    .pcpi_wait(wait_o[2]), .pcpi_ready(ready_o[2]), .x_fn(fn_o[2]),
    .x_imm(imm_o[2]), .x_in1(in1_o[2]), .x_in2(in2_o[2]), .x_val(xval_o[2]),
    .x_oval(x_oval), .x_out(x_out));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  // age = cycles since the operation was accepted (0 = no operation);
  // parked = waiting for the core to drop valid after a finished operation.
  int          latv [3] = '{0, 3, 5};
  int          age  [3] = '{0, 0, 0};
  bit          parked [3] = '{0, 0, 0};
  logic [31:0] m_rd  [3] = '{default: '0};
  logic [31:0] m_in1 [3] = '{default: '0};
  logic [31:0] m_in2 [3] = '{default: '0};
  logic [5:0]  m_fn  [3] = '{default: '0};
  logic [6:0]  m_imm [3] = '{default: '0};
  int          n_ready [3] = '{0, 0, 0};
  int          n_xval  [3] = '{0, 0, 0};
  int          n_wait  [3] = '{0, 0, 0};
  bit          started = 1'b0;

  function automatic bit is_custom(input logic [31:0] w);
    return (w[6:0] == 7'h0B) || (w[6:0] == 7'h2B) ||
           (w[6:0] == 7'h5B) || (w[6:0] == 7'h7B);
  endfunction

  function automatic logic [1:0] cust_of(input logic [31:0] w);
    case (w[6:0])
      7'h2B:   return 2'd1;
      7'h5B:   return 2'd2;
      7'h7B:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    bit busy, rdy;
    for (int k = 0; k < 3; k++) begin
      busy = (age[k] >= 1) && (age[k] <= latv[k] + 1);
      rdy  = (age[k] == latv[k] + 2);
      if (started) begin
        chk($sformatf("u%0d.wait", k),  32'(wait_o[k]),  32'(busy));
        chk($sformatf("u%0d.x_val", k), 32'(xval_o[k]),  32'(busy));
        chk($sformatf("u%0d.ready", k), 32'(ready_o[k]), 32'(rdy));
        chk($sformatf("u%0d.wr", k),    32'(wr_o[k]),    32'(rdy));
        chk($sformatf("u%0d.rd", k),    rd_o[k],         m_rd[k]);
        chk($sformatf("u%0d.fn", k),    32'(fn_o[k]),    32'(m_fn[k]));
        chk($sformatf("u%0d.imm", k),   32'(imm_o[k]),   32'(m_imm[k]));
        chk($sformatf("u%0d.in1", k),   in1_o[k],        m_in1[k]);
        chk($sformatf("u%0d.in2", k),   in2_o[k],        m_in2[k]);
        n_ready[k] += int'(ready_o[k]);
        n_xval[k]  += int'(xval_o[k]);
        n_wait[k]  += int'(wait_o[k]);
      end
      // effect of the coming clock edge
      if (rst) begin
        age[k] = 0; parked[k] = 1'b0;
        m_rd[k] = '0; m_in1[k] = '0; m_in2[k] = '0; m_fn[k] = '0; m_imm[k] = '0;
      end else if (parked[k]) begin
        if (!valid) parked[k] = 1'b0;
      end else if (age[k] == 0) begin
        if (valid && is_custom(insn)) begin
          m_fn[k]  = {1'b0, insn[14:12], cust_of(insn)};
          m_imm[k] = insn[31:25];
          m_in1[k] = rs1;
          m_in2[k] = rs2;
          age[k]   = 1;
        end
      end else if (age[k] <= latv[k]) begin
        age[k]++;
      end else if (age[k] == latv[k] + 1) begin
        if (x_oval) begin
          m_rd[k] = x_out;
          age[k]  = latv[k] + 2;
        end else begin
          age[k] = 0; parked[k] = 1'b1;
        end
      end else begin
        age[k] = 0; parked[k] = 1'b1;
      end
    end
    if (rst) started = 1'b1;
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int r0, r1, r2, v1, w0, w1;
    logic [31:0] s;

    step(2);
    rst = 1'b0;
    chk("rst.rd", rd_o[0], 32'h0);
    chk("rst.fn", 32'(fn_o[0]), 32'h0);
    chk("rst.wait", 32'(wait_o[0]), 32'h0);
    chk("rst.ready", 32'(ready_o[0]), 32'h0);

    // claimed op, constant stub result
    r0 = n_ready[0]; v1 = n_xval[1]; w1 = n_wait[1];
    insn = 32'h0420857B; rs1 = 32'h01234567; rs2 = 32'h89ABCDEF;
    x_oval = 1'b1; xo_inc = 1'b0; xo_const = 32'hDEADBEEF; valid = 1'b1;
    step(1);
    chk("t1.xval0", 32'(xval_o[0]), 32'h1);
    chk("t1.fn0", 32'(fn_o[0]), 32'h03);
    chk("t1.imm0", 32'(imm_o[0]), 32'h02);
    chk("t1.in1", in1_o[0], 32'h01234567);
    chk("t1.in2", in2_o[0], 32'h89ABCDEF);
    rs1 = 32'hFFFF0000;
    step(1);
    chk("t1.ready0", 32'(ready_o[0]), 32'h1);
    chk("t1.wr0", 32'(wr_o[0]), 32'h1);
    chk("t1.rd0", rd_o[0], 32'hDEADBEEF);
    chk("t1.xval0_off", 32'(xval_o[0]), 32'h0);
    step(3);
    chk("t1.ready1", 32'(ready_o[1]), 32'h1);
    chk("t1.rd1", rd_o[1], 32'hDEADBEEF);
    step(5);
    valid = 1'b0;
    step(3);
    chk("t1.nready0", 32'(n_ready[0] - r0), 32'd1);
    chk("t1.nxval1", 32'(n_xval[1] - v1), 32'd4);
    chk("t1.nwait1", 32'(n_wait[1] - w1), 32'd4);

    // LAT=3 captures only the last EXEC cycle's result
    rs1 = 32'h01234567;
    xo_inc = 1'b1; valid = 1'b1; s = cyc_q;
    step(5);
    chk("t2.ready1", 32'(ready_o[1]), 32'h1);
    chk("t2.rd1", rd_o[1], 32'hA500_0000 ^ (s + 32'd4));
    step(3);
    valid = 1'b0;
    step(3);

    // non-custom word
    r0 = n_ready[0]; r1 = n_ready[1]; w0 = n_wait[0]; v1 = n_xval[1];
    insn = 32'h00B50533; valid = 1'b1;
    step(20);
    valid = 1'b0;
    step(2);
    chk("t3.nready0", 32'(n_ready[0] - r0), 32'd0);
    chk("t3.nready1", 32'(n_ready[1] - r1), 32'd0);
    chk("t3.nwait0", 32'(n_wait[0] - w0), 32'd0);
    chk("t3.nxval1", 32'(n_xval[1] - v1), 32'd0);

    // unclaimed custom-1 word
    r0 = n_ready[0]; w0 = n_wait[0];
    insn = 32'h0000102B; x_oval = 1'b0; valid = 1'b1;
    step(10);
    valid = 1'b0;
    step(2);
    chk("t4.nready0", 32'(n_ready[0] - r0), 32'd0);
    chk("t4.nwait0", 32'(n_wait[0] - w0), 32'd1);

    // back-to-back with a one-cycle valid gap
    r0 = n_ready[0];
    x_oval = 1'b1; xo_inc = 1'b1;
    insn = 32'h0420857B; rs1 = 32'h1; rs2 = 32'h2; valid = 1'b1; s = cyc_q;
    step(4);
    valid = 1'b0;
    step(1);
    insn = 32'h0620A05B; rs1 = 32'h3; rs2 = 32'h4; valid = 1'b1;
    step(2);
    chk("t5.ready0", 32'(ready_o[0]), 32'h1);
    chk("t5.rd0", rd_o[0], 32'hA500_0000 ^ (s + 32'd6));
    chk("t5.fn0", 32'(fn_o[0]), 32'h0A);
    step(2);
    valid = 1'b0;
    step(3);
    chk("t5.nready0", 32'(n_ready[0] - r0), 32'd2);

    // reset in the middle of a LAT=5 execution
    xo_inc = 1'b0; xo_const = 32'h5A5A1234;
    insn = 32'h0420857B; rs1 = 32'h11111111; rs2 = 32'h22222222; valid = 1'b1;
    step(3);
    chk("t6.busy2", 32'(xval_o[2]), 32'h1);
    rst = 1'b1; valid = 1'b0;
    step(1);
    rst = 1'b0;
    r2 = n_ready[2];
    chk("t6.xval2", 32'(xval_o[2]), 32'h0);
    chk("t6.wait2", 32'(wait_o[2]), 32'h0);
    chk("t6.fn2", 32'(fn_o[2]), 32'h0);
    chk("t6.in1_2", in1_o[2], 32'h0);
    chk("t6.rd2", rd_o[2], 32'h0);
    step(2);
    valid = 1'b1;
    step(12);
    valid = 1'b0;
    step(3);
    chk("t6.nready2", 32'(n_ready[2] - r2), 32'd1);
    chk("t6.rd2_new", rd_o[2], 32'h5A5A1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
